// File: rtl/fake_sram_pkg.sv
// Shared defaults and port-slice helpers for the multi-port flow-table SRAM model.
package fake_sram_pkg;
    localparam int DEF_ADDR_WIDTH    = 10;
    localparam int DEF_DATA_WIDTH    = 72;
    localparam int DEF_NUM_PORTS     = 2;
    localparam int DEF_READ_LATENCY  = 3;
    localparam int DEF_ACCEPT_PERIOD = 4;

    function automatic int addr_slice(input int p, input int aw);
        return p * aw;
    endfunction

    function automatic int data_slice(input int p, input int dw);
        return p * dw;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    int            k;

    always_comb begin
        grant = '0;
        win   = ptr;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                win      = PW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (en && found)
            ptr <= (int'(win) == N - 1) ? '0 : win + PW'(1);
    end
endmodule

// File: rtl/fake_sram_multiport.sv
// Simulation model of a shared flow-table SRAM: slot-paced acceptance, round-robin
// arbitration, fixed-latency pipelined reads and a sticky requester-protocol checker.
module fake_sram_multiport
    import fake_sram_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_PORTS     = DEF_NUM_PORTS,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int ACCEPT_PERIOD = DEF_ACCEPT_PERIOD,
    parameter     INIT_FILE     = ""
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            wr_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_PORTS-1:0]            wr_ack,
    input  logic [NUM_PORTS-1:0]            rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]            rd_ack,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_PORTS-1:0]            rd_vld,
    output logic                            proto_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (ACCEPT_PERIOD > 1) ? $clog2(ACCEPT_PERIOD) : 1;
    localparam int PIDW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] slot_cnt;
    logic          slot;

    always_ff @(posedge clk) begin
        if (reset)
            slot_cnt <= '0;
        else if (slot_cnt == CW'(ACCEPT_PERIOD - 1))
            slot_cnt <= '0;
        else
            slot_cnt <= slot_cnt + CW'(1);
    end

    assign slot = (slot_cnt == '0) && !reset;

    logic [NUM_PORTS-1:0] port_req, grant;

    assign port_req = (wr_req | rd_req) & {NUM_PORTS{slot}};

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (slot),
        .req   (port_req),
        .grant (grant)
    );

    // Within the winning port a write always takes the slot ahead of a read.
    assign wr_ack = grant & wr_req;
    assign rd_ack = grant & ~wr_req & rd_req;

    logic [ADDR_WIDTH-1:0] wr_sel_addr, rd_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;
    logic [PIDW-1:0]       rd_sel_port;

    always_comb begin
        wr_sel_addr = '0;
        wr_sel_data = '0;
        rd_sel_addr = '0;
        rd_sel_port = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_ack[p]) begin
                wr_sel_addr = wr_addr[addr_slice(p, ADDR_WIDTH) +: ADDR_WIDTH];
                wr_sel_data = wr_data[data_slice(p, DATA_WIDTH) +: DATA_WIDTH];
            end
            if (rd_ack[p]) begin
                rd_sel_addr = rd_addr[addr_slice(p, ADDR_WIDTH) +: ADDR_WIDTH];
                rd_sel_port = PIDW'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (|wr_ack) mem[wr_sel_addr] <= wr_sel_data;
    end

    // Stage 0 is the ack cycle; the last stage feeds the registered outputs.
    logic                  s0_vld;
    logic [PIDW-1:0]       s0_port;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  tail_vld;
    logic [PIDW-1:0]       tail_port;
    logic [DATA_WIDTH-1:0] tail_data;

    assign s0_vld  = |rd_ack;
    assign s0_port = rd_sel_port;
    assign s0_data = mem[rd_sel_addr];

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign tail_vld  = s0_vld;
            assign tail_port = s0_port;
            assign tail_data = s0_data;
        end else begin : g_pipe
            localparam int STAGES = READ_LATENCY - 1;
            logic [STAGES:1]                 vld_pipe;
            logic [STAGES:1][PIDW-1:0]       port_pipe;
            logic [STAGES:1][DATA_WIDTH-1:0] data_pipe;

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_pipe <= '0;
                end else begin
                    for (int k = STAGES; k > 1; k--) vld_pipe[k] <= vld_pipe[k-1];
                    vld_pipe[1] <= s0_vld;
                end
            end

            always_ff @(posedge clk) begin
                for (int k = STAGES; k > 1; k--) begin
                    port_pipe[k] <= port_pipe[k-1];
                    data_pipe[k] <= data_pipe[k-1];
                end
                port_pipe[1] <= s0_port;
                data_pipe[1] <= s0_data;
            end

            assign tail_vld  = vld_pipe[STAGES];
            assign tail_port = port_pipe[STAGES];
            assign tail_data = data_pipe[STAGES];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld  <= '0;
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_vld[p] <= tail_vld && (tail_port == PIDW'(p));
                if (tail_vld && (tail_port == PIDW'(p)))
                    rd_data[data_slice(p, DATA_WIDTH) +: DATA_WIDTH] <= tail_data;
            end
        end
    end

    // A request left pending last cycle must reappear unchanged this cycle.
    logic [NUM_PORTS-1:0]            wr_pend_q, rd_pend_q;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data_q;
    logic                            viol;

    always_comb begin
        viol = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_pend_q[p] && (!wr_req[p] ||
                wr_addr[addr_slice(p, ADDR_WIDTH) +: ADDR_WIDTH] != wr_addr_q[addr_slice(p, ADDR_WIDTH) +: ADDR_WIDTH] ||
                wr_data[data_slice(p, DATA_WIDTH) +: DATA_WIDTH] != wr_data_q[data_slice(p, DATA_WIDTH) +: DATA_WIDTH]))
                viol = 1'b1;
            if (rd_pend_q[p] && (!rd_req[p] ||
                rd_addr[addr_slice(p, ADDR_WIDTH) +: ADDR_WIDTH] != rd_addr_q[addr_slice(p, ADDR_WIDTH) +: ADDR_WIDTH]))
                viol = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pend_q <= '0;
            rd_pend_q <= '0;
            proto_err <= 1'b0;
        end else begin
            wr_pend_q <= wr_req & ~wr_ack;
            rd_pend_q <= rd_req & ~rd_ack;
            if (viol) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        wr_addr_q <= wr_addr;
        rd_addr_q <= rd_addr;
        wr_data_q <= wr_data;
    end
endmodule

// File: tb/tb_fake_sram_multiport.sv
// Bench for fake_sram_multiport: directed scenarios plus randomized traffic vs. a transaction model.
module tb_fake_sram_multiport;
    localparam int AW = 10, DW = 72, NP = 2, LAT = 3, AP = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [NP-1:0]    wr_req, rd_req, wr_ack, rd_ack, rd_vld;
    logic [NP*AW-1:0] wr_addr, rd_addr;
    logic [NP*DW-1:0] wr_data, rd_data;
    logic             proto_err;

    logic [0:0]    b_wr_req, b_rd_req, b_wr_ack, b_rd_ack, b_rd_vld;
    logic [AW-1:0] b_wr_addr, b_rd_addr;
    logic [DW-1:0] b_wr_data, b_rd_data;
    logic          b_proto_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } ret_t;

    always #5 clk = ~clk;

    fake_sram_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP),
                          .READ_LATENCY(LAT), .ACCEPT_PERIOD(AP)) u_dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_vld(rd_vld), .proto_err(proto_err)
    );

    fake_sram_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(1),
                          .READ_LATENCY(3), .ACCEPT_PERIOD(1)) u_dut_fast (
        .clk(clk), .reset(reset),
        .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ack(b_wr_ack),
        .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_ack(b_rd_ack),
        .rd_data(b_rd_data), .rd_vld(b_rd_vld), .proto_err(b_proto_err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        b_wr_req = '0; b_rd_req = '0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
    endtask

    // Leaves the caller inside cycle 0 (first non-reset cycle, an accept slot).
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic req, input int addr, input logic [DW-1:0] d);
        wr_req[p] = req;
        wr_addr[p*AW +: AW] = AW'(addr);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic req, input int addr);
        rd_req[p] = req;
        rd_addr[p*AW +: AW] = AW'(addr);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_vld !== 2'b00) begin errors++; $display("FAIL reset_rd_vld: got %b expected 00", rd_vld); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
        checks++; if ({wr_ack, rd_ack} !== 4'b0) begin errors++; $display("FAIL reset_acks: got %b expected 0000", {wr_ack, rd_ack}); end
        checks++; if ({b_rd_vld, b_proto_err} !== 2'b0) begin errors++; $display("FAIL reset_fast: got %b expected 00", {b_rd_vld, b_proto_err}); end
        checks++; if (b_rd_data !== '0) begin errors++; $display("FAIL reset_fast_data: got %h expected 0", b_rd_data); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [NP-1:0] exp;
        do_reset();
        set_wr(0, 1'b1, 5, 72'hAB);
        @(negedge clk);
        checks++; if (wr_ack !== 2'b01 || rd_ack !== 2'b00) begin errors++; $display("FAIL wr_ack_c0: got %b/%b expected 01/00", wr_ack, rd_ack); end
        next_cycle();
        set_wr(0, 1'b0, 0, '0);
        set_rd(0, 1'b1, 5);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp = (c == 4) ? 2'b01 : 2'b00;
            checks++; if (rd_ack !== exp) begin errors++; $display("FAIL rd_ack_c%0d: got %b expected %b", c, rd_ack, exp); end
            exp = (c == 7) ? 2'b01 : 2'b00;
            checks++; if (rd_vld !== exp) begin errors++; $display("FAIL rd_vld_c%0d: got %b expected %b", c, rd_vld, exp); end
            if (c == 7) begin
                checks++; if (rd_data[0 +: DW] !== 72'hAB) begin errors++; $display("FAIL rd_data_c7: got %h expected ab", rd_data[0 +: DW]); end
            end
            next_cycle();
            if (c == 4) set_rd(0, 1'b0, 0);
        end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wr_rd_proto: got %b expected 0", proto_err); end
    endtask

    task automatic test_two_port();
        logic [NP-1:0] ea, ev;
        do_reset();
        set_wr(1, 1'b1, 6, 72'hCD);
        @(negedge clk);
        checks++; if (wr_ack !== 2'b10) begin errors++; $display("FAIL two_port_wr: got %b expected 10", wr_ack); end
        next_cycle();
        do_reset();
        set_rd(0, 1'b1, 5);
        set_rd(1, 1'b1, 6);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            ea = (c == 0 || c == 8) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
            ev = (c == 3 || c == 11) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
            checks++; if (rd_ack !== ea) begin errors++; $display("FAIL two_port_ack_c%0d: got %b expected %b", c, rd_ack, ea); end
            checks++; if (rd_vld !== ev) begin errors++; $display("FAIL two_port_vld_c%0d: got %b expected %b", c, rd_vld, ev); end
            if (ev[0]) begin
                checks++; if (rd_data[0 +: DW] !== 72'hAB) begin errors++; $display("FAIL two_port_d0_c%0d: got %h expected ab", c, rd_data[0 +: DW]); end
            end
            if (ev[1]) begin
                checks++; if (rd_data[DW +: DW] !== 72'hCD) begin errors++; $display("FAIL two_port_d1_c%0d: got %h expected cd", c, rd_data[DW +: DW]); end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_wr_beats_rd();
        logic [DW-1:0] d;
        logic [NP-1:0] exp;
        do_reset();
        d = DW'({$urandom, $urandom, $urandom});
        set_wr(0, 1'b1, 9, d);
        set_rd(0, 1'b1, 9);
        @(negedge clk);
        checks++; if (wr_ack !== 2'b01 || rd_ack !== 2'b00) begin errors++; $display("FAIL wr_first: got %b/%b expected 01/00", wr_ack, rd_ack); end
        next_cycle();
        set_wr(0, 1'b0, 0, '0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            exp = (c == 4) ? 2'b01 : 2'b00;
            checks++; if (rd_ack !== exp) begin errors++; $display("FAIL rd_next_slot_c%0d: got %b expected %b", c, rd_ack, exp); end
            if (c == 7) begin
                checks++; if (rd_vld !== 2'b01 || rd_data[0 +: DW] !== d) begin errors++; $display("FAIL rd_new_data: got %b/%h expected 01/%h", rd_vld, rd_data[0 +: DW], d); end
            end
            next_cycle();
            if (c == 4) set_rd(0, 1'b0, 0);
        end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wr_beats_rd_proto: got %b expected 0", proto_err); end
    endtask

    task automatic test_proto_err();
        do_reset();
        next_cycle();
        set_rd(1, 1'b1, 7);
        next_cycle();
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_hold: got %b expected 0", proto_err); end
        next_cycle();
        set_rd(1, 1'b0, 0);
        next_cycle();
        @(negedge clk);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_drop: got %b expected 1", proto_err); end
        checks++; if (rd_ack !== 2'b00) begin errors++; $display("FAIL proto_no_ack: got %b expected 00", rd_ack); end
        repeat (5) next_cycle();
        @(negedge clk);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
        do_reset();
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_cleared: got %b expected 0", proto_err); end
        next_cycle();
        set_wr(0, 1'b1, 3, 72'h11);
        next_cycle();
        set_wr(0, 1'b1, 3, 72'h12);
        next_cycle();
        @(negedge clk);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_data_change: got %b expected 1", proto_err); end
    endtask

    task automatic test_reset_inflight();
        logic [NP-1:0] exp;
        do_reset();
        set_rd(0, 1'b1, 5);
        @(negedge clk);
        checks++; if (rd_ack !== 2'b01) begin errors++; $display("FAIL inflight_ack: got %b expected 01", rd_ack); end
        next_cycle();
        set_rd(0, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rd_vld !== 2'b00) begin errors++; $display("FAIL inflight_vld_r: got %b expected 00", rd_vld); end
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            if (k == 4) set_rd(0, 1'b1, 5);
            @(negedge clk);
            exp = (k == 7) ? 2'b01 : 2'b00;
            checks++; if (rd_vld !== exp) begin errors++; $display("FAIL inflight_vld_k%0d: got %b expected %b", k, rd_vld, exp); end
            if (k == 7) begin
                checks++; if (rd_data[0 +: DW] !== 72'hAB) begin errors++; $display("FAIL persist_data: got %h expected ab", rd_data[0 +: DW]); end
            end
            next_cycle();
            if (k == 4) set_rd(0, 1'b0, 0);
        end
    endtask

    task automatic test_fast_port();
        logic e;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            b_wr_req  = (c < 3);
            b_wr_addr = AW'(c + 1);
            b_wr_data = DW'(c + 'h100);
            b_rd_req  = (c >= 3 && c < 6);
            b_rd_addr = AW'(c - 2);
            @(negedge clk);
            e = (c < 3);
            checks++; if (b_wr_ack !== e) begin errors++; $display("FAIL fast_wr_ack_c%0d: got %b expected %b", c, b_wr_ack, e); end
            e = (c >= 3 && c < 6);
            checks++; if (b_rd_ack !== e) begin errors++; $display("FAIL fast_rd_ack_c%0d: got %b expected %b", c, b_rd_ack, e); end
            e = (c >= 6);
            checks++; if (b_rd_vld !== e) begin errors++; $display("FAIL fast_vld_c%0d: got %b expected %b", c, b_rd_vld, e); end
            if (c >= 6) begin
                checks++; if (b_rd_data !== DW'(c - 6 + 'h100)) begin errors++; $display("FAIL fast_data_c%0d: got %h expected %h", c, b_rd_data, DW'(c - 6 + 'h100)); end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [DW-1:0] mdl_mem [16];
        bit            known [16];
        bit            wp [NP], rp [NP];
        int            wa [NP], ra [NP];
        logic [DW-1:0] wd [NP], last [NP];
        ret_t          ret [$];
        int            ptr, a, p;
        bit            found;
        logic [NP-1:0] ew, er, ev;
        do_reset();
        ptr = 0;
        for (int i = 0; i < 16; i++) known[i] = 0;
        for (int i = 0; i < NP; i++) begin wp[i] = 0; rp[i] = 0; wa[i] = 0; ra[i] = 0; wd[i] = '0; last[i] = '0; end
        for (int c = 0; c < 440; c++) begin
            for (int q = 0; q < NP; q++) begin
                if (c < 400 && !wp[q] && $urandom_range(0, 2) == 0) begin
                    wp[q] = 1; wa[q] = $urandom_range(0, 15); wd[q] = DW'({$urandom, $urandom, $urandom});
                end
                if (c < 400 && !rp[q] && $urandom_range(0, 2) == 0) begin
                    a = $urandom_range(0, 15);
                    if (known[a]) begin rp[q] = 1; ra[q] = a; end
                end
                set_wr(q, wp[q], wa[q], wd[q]);
                set_rd(q, rp[q], ra[q]);
            end
            @(negedge clk);
            ew = '0; er = '0; found = 0; p = 0;
            if (c % AP == 0) begin
                for (int i = 0; i < NP; i++) begin
                    if (!found && (wp[(ptr + i) % NP] || rp[(ptr + i) % NP])) begin
                        found = 1;
                        p = (ptr + i) % NP;
                    end
                end
                if (found) begin
                    if (wp[p]) ew[p] = 1'b1; else er[p] = 1'b1;
                    ptr = (p + 1) % NP;
                end
            end
            checks++; if (wr_ack !== ew) begin errors++; $display("FAIL rand_wr_ack_c%0d: got %b expected %b", c, wr_ack, ew); end
            checks++; if (rd_ack !== er) begin errors++; $display("FAIL rand_rd_ack_c%0d: got %b expected %b", c, rd_ack, er); end
            ev = '0;
            if (ret.size() > 0 && ret[0].due == c) begin
                ev[ret[0].port] = 1'b1;
                last[ret[0].port] = ret[0].data;
                void'(ret.pop_front());
            end
            checks++; if (rd_vld !== ev) begin errors++; $display("FAIL rand_rd_vld_c%0d: got %b expected %b", c, rd_vld, ev); end
            for (int q = 0; q < NP; q++) begin
                checks++; if (rd_data[q*DW +: DW] !== last[q]) begin errors++; $display("FAIL rand_rd_data_p%0d_c%0d: got %h expected %h", q, c, rd_data[q*DW +: DW], last[q]); end
            end
            if (ew[p]) begin mdl_mem[wa[p]] = wd[p]; known[wa[p]] = 1; wp[p] = 0; end
            if (er[p]) begin ret.push_back('{c + LAT, p, mdl_mem[ra[p]]}); rp[p] = 0; end
            next_cycle();
        end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rand_proto: got %b expected 0", proto_err); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_read();
        test_two_port();
        test_wr_beats_rd();
        test_proto_err();
        test_reset_inflight();
        test_fast_port();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
